// File: rtl/reg_dest_pkg.sv
// Shared types for the destination-register pipeline: stage record, forwarding
// select encoding and the architectural zero register.
package reg_dest_pkg;

  localparam int REG_W = 5;
  localparam logic [REG_W-1:0] ZERO_REG = 5'd31;

  typedef struct packed {
    logic             valid;
    logic             reg_write;
    logic             is_load;
    logic [REG_W-1:0] rd;
  } stage_t;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_MEM = 2'b01,
    FWD_WB  = 2'b10
  } fwd_sel_e;

  // A stage really produces a register value only if it is live, writes, and
  // does not target XZR.
  function automatic logic eff_write(input stage_t s);
    return s.valid & s.reg_write & (s.rd != ZERO_REG);
  endfunction

endpackage

// File: rtl/fwd_sel_cmp.sv
// Forwarding select for one EX operand: newest non-load producer in MEM wins,
// then WB, else the register file.
module fwd_sel_cmp
  import reg_dest_pkg::*;
(
  input  logic             ex_valid,
  input  logic [REG_W-1:0] operand,
  input  stage_t           mem,
  input  stage_t           wb,
  output fwd_sel_e         sel
);

  // WB load results are forwarded like any other value, so its load flag is
  // not consulted here.
  logic unused_wb_load;
  assign unused_wb_load = wb.is_load;

  always_comb begin
    // NOTE: default assignment first so every path drives sel and no latch is inferred.
    sel = FWD_RF;
    if (ex_valid && (operand != ZERO_REG)) begin
      if (eff_write(mem) && (mem.rd == operand) && !mem.is_load) begin
        sel = FWD_MEM;
      end else if (eff_write(wb) && (wb.rd == operand)) begin
        sel = FWD_WB;
      end
    end
  end

endmodule

// File: rtl/reg_dest_pipe.sv
// Destination-register pipeline (EX/MEM/WB), load-use detection and operand
// forwarding selects; drives the register-file write port from WB.
module reg_dest_pipe
  import reg_dest_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall_in,
  input  logic             flush,
  input  logic             id_valid,
  input  logic             id_reg_write,
  input  logic             id_is_load,
  input  logic [REG_W-1:0] id_rd,
  input  logic [REG_W-1:0] id_rn,
  input  logic [REG_W-1:0] id_rm,
  output logic             load_use_stall,
  output logic [1:0]       ex_fwd_a,
  output logic [1:0]       ex_fwd_b,
  output logic             wb_wr_en,
  output logic [REG_W-1:0] wb_wr_reg
);

  stage_t           ex_q, mem_q, wb_q;
  logic [REG_W-1:0] ex_rn, ex_rm;
  fwd_sel_e         fwd_a, fwd_b;

  // A load in EX cannot forward in time to a dependent instruction in ID.
  // While frozen the stall is masked; it re-evaluates once stall_in drops.
  assign load_use_stall = !stall_in && eff_write(ex_q) && ex_q.is_load && id_valid &&
                          ((ex_q.rd == id_rn) || (ex_q.rd == id_rm));

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: every stage register is cleared on reset so no in-flight write survives it.
    if (!rst_n) begin
      ex_q  <= '0;
      ex_rn <= '0;
      ex_rm <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else if (!stall_in) begin
      // NOTE: non-blocking assignments so MEM and WB capture pre-edge values.
      mem_q <= ex_q;
      wb_q  <= mem_q;
      if (flush || load_use_stall) begin
        ex_q  <= '0;
        ex_rn <= '0;
        ex_rm <= '0;
      end else begin
        ex_q  <= '{valid: id_valid, reg_write: id_reg_write, is_load: id_is_load, rd: id_rd};
        ex_rn <= id_rn;
        ex_rm <= id_rm;
      end
    end
  end

  fwd_sel_cmp u_fwd_a (
    .ex_valid (ex_q.valid),
    .operand  (ex_rn),
    .mem      (mem_q),
    .wb       (wb_q),
    .sel      (fwd_a)
  );

  fwd_sel_cmp u_fwd_b (
    .ex_valid (ex_q.valid),
    .operand  (ex_rm),
    .mem      (mem_q),
    .wb       (wb_q),
    .sel      (fwd_b)
  );

  assign ex_fwd_a  = fwd_a;
  assign ex_fwd_b  = fwd_b;
  assign wb_wr_en  = eff_write(wb_q);
  assign wb_wr_reg = wb_q.rd;

endmodule

// File: tb/tb_reg_dest_pipe.sv
// Bench for reg_dest_pipe: instruction-level pipeline model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_reg_dest_pipe;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       stall_in = 1'b0, flush = 1'b0;
  logic       id_valid = 1'b0, id_reg_write = 1'b0, id_is_load = 1'b0;
  logic [4:0] id_rd = '0, id_rn = '0, id_rm = '0;
  logic       load_use_stall, wb_wr_en;
  logic [1:0] ex_fwd_a, ex_fwd_b;
  logic [4:0] wb_wr_reg;

  int n_vec = 0;
  int n_err = 0;

  reg_dest_pipe dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall_in       (stall_in),
    .flush          (flush),
    .id_valid       (id_valid),
    .id_reg_write   (id_reg_write),
    .id_is_load     (id_is_load),
    .id_rd          (id_rd),
    .id_rn          (id_rn),
    .id_rm          (id_rm),
    .load_use_stall (load_use_stall),
    .ex_fwd_a       (ex_fwd_a),
    .ex_fwd_b       (ex_fwd_b),
    .wb_wr_en       (wb_wr_en),
    .wb_wr_reg      (wb_wr_reg)
  );

  always #5 clk = ~clk;

  // Reference model: one instruction record per slot (0=EX, 1=MEM, 2=WB).
  typedef struct {
    bit         valid, w, ld;
    logic [4:0] rd, rn, rm;
  } ins_t;

  ins_t slot [3];

  function automatic bit writes(input ins_t i);
    return i.valid && i.w && (i.rd != 5'd31);
  endfunction

  function automatic bit exp_stall();
    return !stall_in && writes(slot[0]) && slot[0].ld && id_valid &&
           (slot[0].rd == id_rn || slot[0].rd == id_rm);
  endfunction

  // Scan older instructions newest-first; a load still in MEM cannot supply data.
  function automatic logic [1:0] exp_fwd(input logic [4:0] op);
    if (!slot[0].valid || op == 5'd31) return 2'b00;
    for (int k = 1; k <= 2; k++)
      if (writes(slot[k]) && slot[k].rd == op && !(k == 1 && slot[k].ld))
        return (k == 1) ? 2'b01 : 2'b10;
    return 2'b00;
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < 3; k++) slot[k] = '{default: 0};
  endfunction

  function automatic void model_step();
    bit bubble;
    if (stall_in) return;
    bubble  = flush || exp_stall();
    slot[2] = slot[1];
    slot[1] = slot[0];
    if (bubble) slot[0] = '{default: 0};
    else slot[0] = '{valid: id_valid, w: id_reg_write, ld: id_is_load,
                     rd: id_rd, rn: id_rn, rm: id_rm};
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Every-cycle comparison against the model, away from the rising edge.
  always @(negedge clk) begin
    if (rst_n) begin
      check("m_load_use_stall", {7'd0, load_use_stall}, {7'd0, exp_stall()});
      check("m_ex_fwd_a", {6'd0, ex_fwd_a}, {6'd0, exp_fwd(slot[0].rn)});
      check("m_ex_fwd_b", {6'd0, ex_fwd_b}, {6'd0, exp_fwd(slot[0].rm)});
      check("m_wb_wr_en", {7'd0, wb_wr_en}, {7'd0, writes(slot[2])});
      if (slot[2].valid) check("m_wb_wr_reg", {3'd0, wb_wr_reg}, {3'd0, slot[2].rd});
    end
  end

  task automatic drive(input bit v, input bit w, input bit ld,
                       input logic [4:0] rd, input logic [4:0] rn, input logic [4:0] rm,
                       input bit fl = 1'b0, input bit st = 1'b0);
    id_valid = v; id_reg_write = w; id_is_load = ld;
    id_rd = rd; id_rn = rn; id_rm = rm;
    flush = fl; stall_in = st;
  endtask

  task automatic nop();
    drive(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
  endtask

  task automatic step();
    @(posedge clk);
    if (rst_n) model_step();
    #1;
  endtask

  task automatic drain();
    nop();
    repeat (3) step();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_stall"}, {7'd0, load_use_stall}, 8'd0);
    check({tag, "_fwd_a"}, {6'd0, ex_fwd_a}, 8'd0);
    check({tag, "_fwd_b"}, {6'd0, ex_fwd_b}, 8'd0);
    check({tag, "_wr_en"}, {7'd0, wb_wr_en}, 8'd0);
    check({tag, "_wr_reg"}, {3'd0, wb_wr_reg}, 8'd0);
  endtask

  function automatic logic [4:0] rnd_reg();
    return ($urandom_range(0, 9) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    #12;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // ADD X3 ; SUB X5,X3,X1 with 0, 1, 2 NOPs between
    for (int gap = 0; gap < 3; gap++) begin
      drive(1'b1, 1'b1, 1'b0, 5'd3, 5'd0, 5'd0); step();
      nop();
      repeat (gap) step();
      drive(1'b1, 1'b1, 1'b0, 5'd5, 5'd3, 5'd1); step();
      check($sformatf("alu_gap%0d_fwd_a", gap), {6'd0, ex_fwd_a},
            (gap == 0) ? 8'h01 : (gap == 1) ? 8'h02 : 8'h00);
      drain();
    end

    // LDUR X2 ; ADD X4,X2,X2
    drive(1'b1, 1'b1, 1'b1, 5'd2, 5'd0, 5'd0); step();
    drive(1'b1, 1'b1, 1'b0, 5'd4, 5'd2, 5'd2); #1;
    check("lu_stall_on", {7'd0, load_use_stall}, 8'd1);
    step();
    check("lu_stall_off", {7'd0, load_use_stall}, 8'd0);
    step();
    check("lu_fwd_a", {6'd0, ex_fwd_a}, 8'h02);
    check("lu_fwd_b", {6'd0, ex_fwd_b}, 8'h02);
    drain();

    // Load to XZR followed by a reader of XZR
    drive(1'b1, 1'b1, 1'b1, 5'd31, 5'd0, 5'd0); step();
    drive(1'b1, 1'b0, 1'b0, 5'd1, 5'd31, 5'd31); #1;
    check("xzr_stall", {7'd0, load_use_stall}, 8'd0);
    step();
    check("xzr_fwd_a", {6'd0, ex_fwd_a}, 8'h00);
    check("xzr_fwd_b", {6'd0, ex_fwd_b}, 8'h00);
    nop(); step();
    check("xzr_wr_en", {7'd0, wb_wr_en}, 8'd0);
    drain();

    // ADD X7 ; ADD X7 ; reader of X7
    drive(1'b1, 1'b1, 1'b0, 5'd7, 5'd0, 5'd0); step(); step();
    drive(1'b1, 1'b0, 1'b0, 5'd8, 5'd7, 5'd0); step();
    check("dbl_fwd_a", {6'd0, ex_fwd_a}, 8'h01);
    drain();

    // Flushed instruction writing X9 never reaches the register file
    drive(1'b1, 1'b1, 1'b0, 5'd9, 5'd0, 5'd0, 1'b1); step();
    nop();
    for (int k = 0; k < 3; k++) begin
      step();
      check($sformatf("flush_wr_en%0d", k), {7'd0, wb_wr_en}, 8'd0);
    end

    // Three producers, then a 3-cycle external freeze, then resume in order
    for (int r = 10; r <= 12; r++) begin
      drive(1'b1, 1'b1, 1'b0, 5'(r), 5'd0, 5'd0); step();
    end
    check("stall_wr_en", {7'd0, wb_wr_en}, 8'd1);
    check("stall_pre", {3'd0, wb_wr_reg}, 8'd10);
    drive(1'b1, 1'b1, 1'b0, 5'd13, 5'd0, 5'd0, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      step();
      check($sformatf("stall_hold%0d", k), {3'd0, wb_wr_reg}, 8'd10);
    end
    drive(1'b1, 1'b1, 1'b0, 5'd13, 5'd0, 5'd0); step();
    check("resume_11", {3'd0, wb_wr_reg}, 8'd11);
    nop(); step();
    check("resume_12", {3'd0, wb_wr_reg}, 8'd12);
    step();
    check("resume_13", {3'd0, wb_wr_reg}, 8'd13);
    check("resume_wr_en", {7'd0, wb_wr_en}, 8'd1);

    // Asynchronous reset while WB is writing
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check_reset_outputs("async_rst");
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized traffic against the model
    repeat (400) begin
      drive(($urandom_range(0, 9) < 8), ($urandom_range(0, 9) < 8), ($urandom_range(0, 9) < 3),
            rnd_reg(), rnd_reg(), rnd_reg(),
            ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0));
      step();
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
